// File: rtl/tlc1543_responder.sv
// Device-side TLC1543 model: shifts in a 4-bit address, shifts out the previous result, times EOC.
// Latency: pin edges act 4 clk_in cycles after they occur; EOC stays low CONV_CYCLES cycles per conversion.
// Backpressure: none; the controller must respect IOCLK phase >= 4 cycles and must not start a frame during a conversion.
module tlc1543_responder #(
  parameter int unsigned CONV_CYCLES = 2100
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic [109:0] ain,
  input  logic         CS_n,
  input  logic         IOCLK,
  input  logic         ADDR,
  output logic         DOUT,
  output logic         dout_en,
  output logic         EOC,
  output logic         conv_done,
  output logic [3:0]   last_addr
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SHIFT   = 2'd1,
    S_CONVERT = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  localparam logic [15:0] LP_CNT_LOAD = 16'(CONV_CYCLES - 1);

  // Synchronizer stages (s1, s2), edge register (e) and its previous value (d).
  logic r_cs_s1, r_cs_s2, r_cs_e, r_cs_d;
  logic r_ck_s1, r_ck_s2, r_ck_e, r_ck_d;
  logic r_ad_s1, r_ad_s2, r_ad_e;
  logic [2:0] r_warm;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_bit_cnt;
  logic [3:0] r_addr_sr;
  logic [9:0] r_shift_out;
  logic [9:0] r_result;
  logic [15:0] r_cnt;
  logic       r_eoc;
  logic       r_conv_done;
  logic [3:0] r_last_addr;

  logic w_armed;
  logic w_cs_fall, w_cs_rise, w_ck_rise, w_ck_fall;
  logic w_start, w_addr_shift, w_out_shift, w_go_conv, w_latch;
  logic [9:0] w_code;
  logic [6:0] w_idx;

  // Bring the asynchronous controller pins into clk_in and keep one extra stage for edge detection.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_cs_s1 <= 1'b1; r_cs_s2 <= 1'b1; r_cs_e <= 1'b1; r_cs_d <= 1'b1;
      r_ck_s1 <= 1'b0; r_ck_s2 <= 1'b0; r_ck_e <= 1'b0; r_ck_d <= 1'b0;
      r_ad_s1 <= 1'b0; r_ad_s2 <= 1'b0; r_ad_e <= 1'b0;
    end else begin
      r_cs_s1 <= CS_n;  r_cs_s2 <= r_cs_s1; r_cs_e <= r_cs_s2; r_cs_d <= r_cs_e;
      r_ck_s1 <= IOCLK; r_ck_s2 <= r_ck_s1; r_ck_e <= r_ck_s2; r_ck_d <= r_ck_e;
      r_ad_s1 <= ADDR;  r_ad_s2 <= r_ad_s1; r_ad_e <= r_ad_s2;
    end
  end

  // Hold off CS_n falls until the pipeline has flushed: a pin already low at reset release is not a new frame.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_warm <= 3'd0;
    end else if (r_warm != 3'd4) begin
      r_warm <= r_warm + 3'd1;
    end
  end

  assign w_armed   = (r_warm == 3'd4);
  assign w_cs_fall = r_cs_d & ~r_cs_e & w_armed;
  assign w_cs_rise = ~r_cs_d & r_cs_e;
  assign w_ck_rise = ~r_ck_d & r_ck_e;
  assign w_ck_fall = r_ck_d & ~r_ck_e;

  // FSM state register.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath strobes; CS_n rise wins over a coincident IOCLK fall (abort).
  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_addr_shift = 1'b0;
    w_out_shift  = 1'b0;
    w_go_conv    = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) begin
          w_start     = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_cs_rise) begin
          w_state_nxt = S_IDLE;
        end else begin
          if (w_ck_rise && (r_bit_cnt < 4'd4)) begin
            w_addr_shift = 1'b1;
          end
          if (w_ck_fall) begin
            w_out_shift = 1'b1;
            if (r_bit_cnt == 4'd9) begin
              w_go_conv   = 1'b1;
              w_state_nxt = S_CONVERT;
            end
          end
        end
      end
      S_CONVERT: begin
        if (r_cnt == 16'd0) begin
          w_latch     = 1'b1;
          w_state_nxt = r_cs_e ? S_IDLE : S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (r_cs_e) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result code for the latched address; 14 and 15 keep the previous result.
  always_comb begin
    w_code = r_result;
    w_idx  = {3'b000, r_last_addr} * 7'd10;
    case (r_last_addr)
      4'd11:        w_code = 10'h200;
      4'd12:        w_code = 10'h000;
      4'd13:        w_code = 10'h3FF;
      4'd14, 4'd15: w_code = r_result;
      default:      w_code = ain[w_idx +: 10];
    endcase
  end

  // Shift registers, bit counter, conversion timer and result latch.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_bit_cnt   <= 4'd0;
      r_addr_sr   <= 4'd0;
      r_shift_out <= 10'd0;
      r_result    <= 10'd0;
      r_cnt       <= 16'd0;
      r_eoc       <= 1'b1;
      r_conv_done <= 1'b0;
      r_last_addr <= 4'd0;
    end else begin
      r_conv_done <= w_latch;
      if (w_start) begin
        r_bit_cnt   <= 4'd0;
        r_addr_sr   <= 4'd0;
        r_shift_out <= r_result;
      end
      if (w_addr_shift) begin
        r_addr_sr <= {r_addr_sr[2:0], r_ad_e};
      end
      if (w_out_shift) begin
        r_bit_cnt   <= r_bit_cnt + 4'd1;
        r_shift_out <= {r_shift_out[8:0], 1'b0};
      end
      if (w_go_conv) begin
        r_eoc       <= 1'b0;
        r_last_addr <= r_addr_sr;
        r_cnt       <= LP_CNT_LOAD;
      end else if ((r_state == S_CONVERT) && (r_cnt != 16'd0)) begin
        r_cnt <= r_cnt - 16'd1;
      end
      if (w_latch) begin
        r_eoc    <= 1'b1;
        r_result <= w_code;
      end
    end
  end

  // dout_en follows the CS_n stage that the FSM acts on, so DOUT never shows a stale bit.
  assign dout_en   = ~r_cs_d;
  assign DOUT      = dout_en & r_shift_out[9];
  assign EOC       = r_eoc;
  assign conv_done = r_conv_done;
  assign last_addr = r_last_addr;

endmodule

// File: doc/tlc1543_responder.md
# tlc1543_responder

- Synthesizable responder for the TLC1543 10-bit serial ADC interface. It is the device end of the link that our TLC1543 controller drives.
- It samples the controller-driven CS_n, IOCLK and ADDR pins and shifts in a 4-bit channel address. It drives DOUT with the previous conversion result and runs EOC through a timed conversion.
- Result values come from a parallel channel-code vector. This lets the controller be exercised in simulation and on-board without a real ADC.

## Interface
Parameters:
- CONV_CYCLES, default 2100: clk_in cycles EOC stays low per conversion (21 µs at 100 MHz); legal range 2..65535.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- ain  input  110  channel codes; channel k = ain[10k+9:10k], k = 0..10.
- CS_n  input  1  chip select from controller, asynchronous to clk_in.
- IOCLK  input  1  serial clock from controller, asynchronous to clk_in.
- ADDR  input  1  serial address from controller, MSB first.
- DOUT  output  1  serial result, MSB first.
- dout_en  output  1  high while CS_n (synchronized) is low; tristate enable for board use.
- EOC  output  1  end of conversion; high = result ready/idle.
- conv_done  output  1  one-cycle pulse when a result is latched.
- last_addr  output  4  address of the most recent accepted frame.

## Operation
- CS_n, IOCLK and ADDR each pass through a 2-flop synchronizer; IOCLK and CS_n get registered edge detection after that.
- States:
  - IDLE: EOC=1. Synced CS_n falling -> SHIFT; clear bit counter (4 bits); load shift_out <= result.
  - SHIFT, on IOCLK rising:
    - If bit count < 4, addr_sr <= {addr_sr[2:0], ADDR_sync}.
  - SHIFT, on IOCLK falling:
    - Bit count increments.
    - shift_out <= {shift_out[8:0], 1'b0}.
    - On the 10th falling edge: EOC <= 0, last_addr <= addr_sr, load the conversion counter, -> CONVERT.
  - SHIFT, on CS_n rising before the 10th falling edge: frame aborted, no conversion, EOC stays 1, -> IDLE.
  - CONVERT: counter decrements each cycle; IOCLK/ADDR ignored. When it reaches 0:
    - result <= code(last_addr), conv_done=1, EOC <= 1.
    - Next state: IDLE if CS_n is high, else LOCKED.
  - LOCKED: EOC=1; IOCLK ignored; CS_n rising -> IDLE. A new frame needs a fresh CS_n falling edge.
- code(a):
  - a = 0..10: channel a of ain, sampled on the latch cycle.
  - a = 11: 10'h200.
  - a = 12: 10'h000.
  - a = 13: 10'h3FF.
  - a = 14, 15: result unchanged, but conv_done and EOC behave normally.
- DOUT = shift_out[9] when dout_en=1, else 0. Bits after the 10th shift are 0.
- CS_n falling while in CONVERT: the frame is ignored. The conversion completes, then the FSM enters LOCKED.

## Timing
- Reset values: DOUT=0, dout_en=0, EOC=1, conv_done=0, last_addr=0, result=0, state IDLE. Synchronizers clear to CS_n=1, IOCLK=0.
- Reset asserted in any state aborts the frame or conversion immediately. After deassertion the block needs a new CS_n falling edge.
- Pin-to-internal edge latency is 3 clk_in cycles (2 sync + edge register).
- DOUT MSB is valid 4 cycles after CS_n falls. Each later bit is valid 4 cycles after the IOCLK falling pin edge.
- EOC falls 4 cycles after the 10th IOCLK falling pin edge.
- EOC stays low exactly CONV_CYCLES cycles. conv_done pulses in the same cycle that EOC returns high.
- Controller requirement: IOCLK high and low phases each ≥ 4 clk_in periods; ADDR stable ≥ 3 cycles around IOCLK rising.
- IOCLK edges coincident (same synced cycle) with CS_n falling are ignored. IOCLK falling coincident with CS_n rising counts as abort.
- More than 10 IOCLK clocks in SHIFT cannot occur: the FSM leaves SHIFT on the 10th.

## Test plan
- After reset: EOC=1, DOUT=0, dout_en=0, result=0. Frame with address 4'b0101 and ain ch5=10'h2A5 -> DOUT shifts 0x000, EOC low for CONV_CYCLES, conv_done once, last_addr=5. Next frame shifts 10'h2A5.
- Address 11, 12, 13 in consecutive frames -> following frames read 10'h200, 10'h000, 10'h3FF.
- CS_n raised after 6 IOCLK clocks -> EOC stays 1, no conv_done, result and last_addr unchanged.
- CS_n held low through the conversion with extra IOCLK pulses -> LOCKED. No DOUT shifts and no second conversion until CS_n toggles.
- Reset asserted mid-CONVERT -> EOC=1 and result=0 within 1 cycle, no conv_done. The next full frame converts normally.
- Closed loop with the TLC1543 controller (100 MHz system clock, 1 MHz SPI), channel 3 = 10'h155 -> the controller's data reads 10'h155 with data_valid asserted.
